// File: rtl/rbm_pkg.sv
// rtl/rbm_pkg.sv - shared FSM type, PLAN sigmoid constants, LFSR and saturating-add helpers
// Contents: state_t, PLAN_* breakpoints/offsets/slopes, LFSR_* constants, lfsr_step(), sat_add().
package rbm_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MAC,
    S_DRAIN,
    S_SIG,
    S_SAMPLE,
    S_DONE
  } state_t;

  // PLAN breakpoints on |x|, in units of 1/8 so 2.375 stays an integer
  localparam int unsigned PLAN_BP_SAT8 = 40;  // 5.0
  localparam int unsigned PLAN_BP_MID8 = 19;  // 2.375
  localparam int unsigned PLAN_BP_LIN8 = 8;   // 1.0

  // PLAN offsets in units of 1/32
  localparam int unsigned PLAN_OFF_HI32  = 27;  // 0.84375
  localparam int unsigned PLAN_OFF_MID32 = 20;  // 0.625
  localparam int unsigned PLAN_OFF_LO32  = 16;  // 0.5
  localparam int unsigned PLAN_ONE32     = 32;  // 1.0

  // PLAN slopes as left shifts relative to 1/32
  localparam int unsigned PLAN_SH_HI  = 0;  // 0.03125
  localparam int unsigned PLAN_SH_MID = 2;  // 0.125
  localparam int unsigned PLAN_SH_LO  = 3;  // 0.25

  // Right-shifting Galois form of x^16+x^14+x^13+x^11+1
  localparam logic [15:0] LFSR_POLY_MASK    = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_POLY_MASK) : (s >> 1);
  endfunction

  // Signed add clamped to a width-bit two's complement range (width <= 31)
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int width);
    logic signed [32:0] sum;
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    sum = {a[31], a} + {b[31], b};
    hi  = (33'sd1 <<< (width - 1)) - 33'sd1;
    lo  = -(33'sd1 <<< (width - 1));
    if (sum > hi) sum = hi;
    else if (sum < lo) sum = lo;
    return sum[31:0];
  endfunction

endpackage

// File: rtl/rbm_sigmoid_plan.sv
// rtl/rbm_sigmoid_plan.sv - combinational piecewise-linear (PLAN) sigmoid
// Ports: acc (signed, FRAC_W fraction bits) in; prob (unsigned, SG_W fraction bits) out.
module rbm_sigmoid_plan
  import rbm_pkg::*;
#(
  parameter int ACC_W  = 16,
  parameter int FRAC_W = 4,
  parameter int SG_W   = 8
) (
  input  logic [ACC_W-1:0] acc,
  output logic [SG_W-1:0]  prob
);

  // Internal result carries FRAC_W+5 fraction bits, so every slope/offset is exact
  localparam int unsigned Q = FRAC_W + 5;
  localparam logic [63:0] ONE = 64'(PLAN_ONE32) << FRAC_W;

  logic signed [63:0] xs;
  logic [63:0] mag;
  logic [63:0] mag8;
  logic [63:0] y_pos;
  logic [63:0] y;

  always_comb begin
    xs   = 64'($signed(acc));
    mag  = xs[63] ? 64'(-xs) : 64'(xs);
    mag8 = mag << 3;
    if (mag8 >= (64'(PLAN_BP_SAT8) << FRAC_W))
      y_pos = ONE;
    else if (mag8 >= (64'(PLAN_BP_MID8) << FRAC_W))
      y_pos = (mag << PLAN_SH_HI) + (64'(PLAN_OFF_HI32) << FRAC_W);
    else if (mag8 >= (64'(PLAN_BP_LIN8) << FRAC_W))
      y_pos = (mag << PLAN_SH_MID) + (64'(PLAN_OFF_MID32) << FRAC_W);
    else
      y_pos = (mag << PLAN_SH_LO) + (64'(PLAN_OFF_LO32) << FRAC_W);
    y = xs[63] ? (ONE - y_pos) : y_pos;
    // 1.0 has no SG_W-bit encoding, so it clamps to all-ones; else truncate
    prob = (y >= ONE) ? '1 : SG_W'((y << SG_W) >> Q);
  end

endmodule

// File: rtl/rbm_gibbs_layer.sv
// rtl/rbm_gibbs_layer.sv - sequential RBM hidden-layer sampler with one time-multiplexed MAC
// Ports: clock, reset (sync, active-high), start, vis, bias (packed per unit),
//        w_rd/w_addr/w_data (1-cycle-latency weight memory), busy, done, hid.
// Option: RBM_PROB_OUT_EN adds prob_o (per-unit sigmoid values, updated with hid).
module rbm_gibbs_layer
  import rbm_pkg::*;
#(
  parameter int          IN_DIM    = 6,
  parameter int          OUT_DIM   = 5,
  parameter int          DATA_W    = 8,
  parameter int          FRAC_W    = 4,
  parameter int          ACC_W     = 16,
  parameter int          SG_W      = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              start,
  input  logic [IN_DIM-1:0]                 vis,
  input  logic [OUT_DIM*DATA_W-1:0]         bias,
  output logic                              w_rd,
  output logic [$clog2(IN_DIM*OUT_DIM)-1:0] w_addr,
  input  logic [DATA_W-1:0]                 w_data,
  output logic                              busy,
  output logic                              done,
  output logic [OUT_DIM-1:0]                hid
`ifdef RBM_PROB_OUT_EN
  ,
  output logic [OUT_DIM*SG_W-1:0]           prob_o
`endif
);

  localparam int AW = $clog2(IN_DIM * OUT_DIM);
  localparam int IW = (IN_DIM > 1) ? $clog2(IN_DIM) : 1;
  localparam int JW = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
  localparam logic [15:0] SEED = (LFSR_SEED == 16'h0) ? LFSR_DEFAULT_SEED : LFSR_SEED;

  state_t             state, state_n;
  logic               accept, last_i, last_j, sample_bit;
  logic [IN_DIM-1:0]  vis_q;
  logic [IW-1:0]      i_cnt;
  logic [JW-1:0]      j_cnt;
  logic [AW-1:0]      addr;
  logic [ACC_W-1:0]   acc;
  logic               rd_d, vbit_d;
  logic [DATA_W-1:0]  bias_j;
  logic [SG_W-1:0]    prob, prob_c, rnd;
  logic [15:0]        lfsr;
  logic [OUT_DIM-1:0] hid_shadow, hid_merged;

  // DONE also accepts, so back-to-back passes lose no cycle
  assign accept     = start && ((state == S_IDLE) || (state == S_DONE));
  assign last_i     = (i_cnt == IW'(IN_DIM - 1));
  assign last_j     = (j_cnt == JW'(OUT_DIM - 1));
  assign rnd        = lfsr[15 -: SG_W];
  assign sample_bit = (prob == '1) || (prob > rnd);
  assign w_addr     = addr;

  always_comb begin
    bias_j     = '0;
    hid_merged = hid_shadow;
    for (int k = 0; k < OUT_DIM; k++) begin
      if (j_cnt == JW'(k)) begin
        bias_j        = bias[k*DATA_W +: DATA_W];
        hid_merged[k] = sample_bit;
      end
    end
  end

  rbm_sigmoid_plan #(
    .ACC_W (ACC_W),
    .FRAC_W(FRAC_W),
    .SG_W  (SG_W)
  ) u_sigmoid (
    .acc (acc),
    .prob(prob_c)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    busy    = 1'b1;
    done    = 1'b0;
    w_rd    = 1'b0;
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_n = S_LOAD;
      end
      S_LOAD:   state_n = S_MAC;
      S_MAC: begin
        w_rd = 1'b1;
        if (last_i) state_n = S_DRAIN;
      end
      S_DRAIN:  state_n = S_SIG;
      S_SIG:    state_n = S_SAMPLE;
      S_SAMPLE: state_n = last_j ? S_DONE : S_LOAD;
      S_DONE: begin
        done    = 1'b1;
        state_n = start ? S_LOAD : S_IDLE;
      end
      default:  state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vis_q      <= '0;
      i_cnt      <= '0;
      j_cnt      <= '0;
      addr       <= '0;
      acc        <= '0;
      rd_d       <= 1'b0;
      vbit_d     <= 1'b0;
      prob       <= '0;
      hid_shadow <= '0;
      hid        <= '0;
      lfsr       <= SEED;
    end else begin
      // Weight data lags the strobe by one cycle; delay the strobe and vis bit to match
      rd_d   <= w_rd;
      vbit_d <= vis_q[i_cnt];
      if (accept) begin
        vis_q <= vis;
        j_cnt <= '0;
        addr  <= '0;
      end
      if (state == S_LOAD)
        acc <= ACC_W'($signed(bias_j));
      else if (rd_d && vbit_d)
        acc <= ACC_W'(sat_add(32'($signed(acc)), 32'($signed(w_data)), ACC_W));
      if (state == S_LOAD) i_cnt <= '0;
      if (state == S_MAC) begin
        i_cnt <= last_i ? '0 : i_cnt + 1'b1;
        addr  <= addr + 1'b1;
      end
      if (state == S_SIG) prob <= prob_c;
      if (state == S_SAMPLE) begin
        hid_shadow <= hid_merged;
        lfsr       <= lfsr_step(lfsr);
        j_cnt      <= last_j ? '0 : j_cnt + 1'b1;
        // Publish with the last unit merged in, so hid is valid during done
        if (last_j) hid <= hid_merged;
      end
    end
  end

`ifdef RBM_PROB_OUT_EN
  logic [OUT_DIM*SG_W-1:0] prob_shadow, prob_merged;

  always_comb begin
    prob_merged = prob_shadow;
    for (int k = 0; k < OUT_DIM; k++) begin
      if (j_cnt == JW'(k)) prob_merged[k*SG_W +: SG_W] = prob;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      prob_shadow <= '0;
      prob_o      <= '0;
    end else if (state == S_SAMPLE) begin
      prob_shadow <= prob_merged;
      if (last_j) prob_o <= prob_merged;
    end
  end
`endif

endmodule

// File: tb/tb_rbm_gibbs_layer.sv
// tb/tb_rbm_gibbs_layer.sv - directed self-checking bench for rbm_gibbs_layer
// Config: IN_DIM=4, OUT_DIM=3, DATA_W=8, FRAC_W=4, ACC_W=16, SG_W=8; honours RBM_PROB_OUT_EN.
module tb_rbm_gibbs_layer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  vis   = 4'h0;
  logic [23:0] bias  = 24'h0;
  logic        w_rd;
  logic [3:0]  w_addr;
  logic [7:0]  w_data = 8'h0;
  logic        busy;
  logic        done;
  logic [2:0]  hid;
`ifdef RBM_PROB_OUT_EN
  logic [23:0] prob_o;
`endif

  logic [7:0] mem [0:11];
  int n_chk  = 0;
  int n_fail = 0;

  rbm_gibbs_layer #(
    .IN_DIM(4), .OUT_DIM(3), .DATA_W(8), .FRAC_W(4), .ACC_W(16), .SG_W(8),
    .LFSR_SEED(16'hACE1)
  ) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .vis   (vis),
    .bias  (bias),
    .w_rd  (w_rd),
    .w_addr(w_addr),
    .w_data(w_data),
    .busy  (busy),
    .done  (done),
    .hid   (hid)
`ifdef RBM_PROB_OUT_EN
    ,
    .prob_o(prob_o)
`endif
  );

  always #5 clock = ~clock;

  // Weight memory with one cycle of read latency
  always @(posedge clock) if (w_rd) w_data <= mem[w_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill_mem(input logic [7:0] val);
    for (int k = 0; k < 12; k++) mem[k] = val;
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".done"}, 32'(done), 32'd0);
    chk({tag, ".w_rd"}, 32'(w_rd), 32'd0);
    chk({tag, ".w_addr"}, 32'(w_addr), 32'd0);
    chk({tag, ".hid"}, 32'(hid), 32'd0);
`ifdef RBM_PROB_OUT_EN
    chk({tag, ".prob_o"}, 32'(prob_o), 32'd0);
`endif
  endtask

  // Called #1 after an edge with the DUT in IDLE or DONE; cycle 1 follows the accepting edge.
  task automatic run_pass(input string tag, input logic [3:0] v, input logic [23:0] b,
                          input bit pulse, input bit flip, input bit chain,
                          input logic [2:0] exp_hid, input logic [23:0] exp_prob);
    logic [31:0] bm, dm, rm;
    int k, aerr, last;
    bm = 0; dm = 0; rm = 0; k = 0; aerr = 0;
    vis = v; bias = b; start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    last = chain ? 25 : 26;
    for (int c = 1; c <= last; c++) begin
      bm[c] = busy;
      dm[c] = done;
      rm[c] = w_rd;
      if (w_rd) begin
        if (w_addr !== 4'(k)) aerr++;
        k++;
      end
      if (c == 25) begin
        chk({tag, ".hid"}, 32'(hid), 32'(exp_hid));
`ifdef RBM_PROB_OUT_EN
        chk({tag, ".prob_o"}, 32'(prob_o), 32'(exp_prob));
`endif
      end
      if (c == last) break;
      start = pulse && (c == 5);
      if (flip && c == 3) vis = ~v;
      @(posedge clock);
      #1;
    end
    start = 1'b0;
    chk({tag, ".busy_cycles"}, bm, 32'h03FF_FFFE);
    chk({tag, ".done_cycles"}, dm, 32'h0200_0000);
    chk({tag, ".w_rd_cycles"}, rm, 32'h003C_3C3C);
    chk({tag, ".w_rd_count"}, 32'(k), 32'd12);
    chk({tag, ".addr_errors"}, 32'(aerr), 32'd0);
  endtask

  initial begin
    logic [31:0] dseen;

    // Reset values
    do_reset("reset0");

    // Sequencing + saturate high, with an ignored start pulse mid-pass
    fill_mem(8'h7F);
    run_pass("sat_hi", 4'b1111, 24'h0, 1'b1, 1'b0, 1'b0, 3'b111, 24'hFFFFFF);

    // Saturate low
    fill_mem(8'h80);
    run_pass("sat_lo", 4'b1111, 24'h0, 1'b0, 1'b0, 1'b0, 3'b000, 24'h000000);

    // Midpoint: three back-to-back passes against the LFSR from seed ACE1.
    // rnd per unit: AC E2 71 | 38 1C 0E | B3 ED C2, compared with prob 0x80
    do_reset("reset1");
    fill_mem(8'h7F);
    run_pass("mid_p1", 4'b0000, 24'h0, 1'b0, 1'b1, 1'b1, 3'b100, 24'h808080);
    run_pass("mid_p2", 4'b0000, 24'h0, 1'b0, 1'b0, 1'b1, 3'b111, 24'h808080);
    run_pass("mid_p3", 4'b0000, 24'h0, 1'b0, 1'b0, 1'b0, 3'b000, 24'h808080);

    // PLAN segments near the sample threshold (fresh LFSR)
    // x = 0.75, 2.0625, -0.1875 -> B0 (>AC), E2 (not >E2), 74 (>71)
    do_reset("reset2");
    run_pass("plan_a", 4'b0000, 24'hFD210C, 1'b0, 1'b0, 1'b0, 3'b101, 24'h74E2B0);
    // x = 4.75, -2, 3 -> FE, 20 (>1C), F0
    run_pass("plan_b", 4'b0000, 24'h30E04C, 1'b0, 1'b0, 1'b0, 3'b111, 24'hF020FE);

    // Reset in cycle 10 of a pass
    vis = 4'b0000; bias = 24'h0; start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    chk("midrst.busy", 32'(busy), 32'd0);
    chk("midrst.done", 32'(done), 32'd0);
    chk("midrst.w_rd", 32'(w_rd), 32'd0);
    chk("midrst.hid", 32'(hid), 32'd0);
    dseen = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clock);
      #1;
      dseen = dseen | 32'(done) | 32'(busy);
    end
    chk("midrst.no_done", dseen, 32'd0);
    // LFSR restarts from the seed
    run_pass("restart", 4'b0000, 24'h0, 1'b0, 1'b0, 1'b0, 3'b100, 24'h808080);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
